// File: rtl/raw_frame_gen.sv
// raw_frame_gen - synthetic camera source
//
// Generates a 12-bit raw Bayer pixel stream with line/frame valid strobes
// and pixel coordinates, standing in for the CCD capture path ahead of the
// greyscale/Sobel pipeline. Each frame is V_ACTIVE lines of H_ACTIVE pixels.
// Lines are separated by H_BLANK idle cycles. The last line is followed by
// V_BLANK idle cycles before the next frame starts or the block goes idle.
//
// Optional feature (macro RAW_FRAME_GEN_STALL_EN):
//   Adds an iREADY input. While iREADY is low in ACTIVE the current pixel is
//   held back (oDVAL=0, oLVAL/oFVAL=1). It is emitted once iREADY returns.
//   Without the macro the block behaves as if iREADY were tied high.
//
// Ports:
//   iCLK         clock
//   iRST         asynchronous active-low reset
//   iSTART       start pulse; only honoured when idle
//   iSTOP        stop request; the current frame completes first
//   iMODE        test pattern select, sampled at each frame start
//   iREADY       downstream ready (only with RAW_FRAME_GEN_STALL_EN)
//   oDATA        raw pixel; holds its value while oDVAL=0
//   oDVAL        pixel valid
//   oLVAL        line valid
//   oFVAL        frame valid
//   oX_Cont      column of the current pixel
//   oY_Cont      row of the current pixel
//   oFrame_Cont  number of completed frames (wraps)
//   oBUSY        high whenever the generator is not idle
//
// Every output is a register. Each state transition loads the output
// registers with the values for the cycle that follows it.

module raw_frame_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic [1:0]  iMODE,
`ifdef RAW_FRAME_GEN_STALL_EN
    input  logic        iREADY,
`endif
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic        oLVAL,
    output logic        oFVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBUSY
);

    // The blank counter is shared by HBLANK and VBLANK.
    // It is sized for the longer of the two blanking intervals.
    localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] VB_LAST = BW'(V_BLANK - 1);
    localparam logic [10:0]   X_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0]   Y_LAST  = 11'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      mode;       // pattern latched for the frame in flight
    logic            stopPend;
    logic [BW-1:0]   blankCnt;
    logic            ready;

`ifdef RAW_FRAME_GEN_STALL_EN
    assign ready = iREADY;
`else
    assign ready = 1'b1;
`endif

    // Pixel value for coordinate (x, y) under pattern m.
    function automatic logic [11:0] pixel(input logic [1:0]  m,
                                          input logic [10:0] x,
                                          input logic [10:0] y);
        logic [11:0] p;
        p = 12'h000;
        case (m)
            2'd0: p = {1'b0, x};
            2'd1: p = {1'b0, y};
            2'd2: p = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
            default: begin
                // Bayer tile G1 R / B G2
                case ({y[0], x[0]})
                    2'b00:   p = 12'h800;
                    2'b01:   p = 12'hFFF;
                    2'b10:   p = 12'h000;
                    default: p = 12'h800;
                endcase
            end
        endcase
        return p;
    endfunction

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state       <= IDLE;
            mode        <= 2'd0;
            stopPend    <= 1'b0;
            blankCnt    <= '0;
            oDATA       <= 12'h000;
            oDVAL       <= 1'b0;
            oLVAL       <= 1'b0;
            oFVAL       <= 1'b0;
            oX_Cont     <= 11'd0;
            oY_Cont     <= 11'd0;
            oFrame_Cont <= 32'd0;
            oBUSY       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A stop arriving with the start is dropped.
                    // A stop arriving alone while idle is ignored.
                    if (iSTART) begin
                        state    <= ACTIVE;
                        mode     <= iMODE;
                        stopPend <= 1'b0;
                        oX_Cont  <= 11'd0;
                        oY_Cont  <= 11'd0;
                        oDATA    <= pixel(iMODE, 11'd0, 11'd0);
                        oDVAL    <= ready;
                        oLVAL    <= 1'b1;
                        oFVAL    <= 1'b1;
                        oBUSY    <= 1'b1;
                    end
                end

                ACTIVE: begin
                    if (iSTOP) stopPend <= 1'b1;
                    // The shown pixel counts as delivered only if oDVAL was
                    // high. Otherwise it stays pending and is offered again.
                    if (oDVAL) begin
                        if (oX_Cont == X_LAST) begin
                            oDVAL    <= 1'b0;
                            oLVAL    <= 1'b0;
                            blankCnt <= '0;
                            if (oY_Cont == Y_LAST) begin
                                state       <= VBLANK;
                                oFVAL       <= 1'b0;
                                oFrame_Cont <= oFrame_Cont + 32'd1;
                            end else begin
                                state <= HBLANK;
                            end
                        end else begin
                            oX_Cont <= oX_Cont + 11'd1;
                            oDATA   <= pixel(mode, oX_Cont + 11'd1, oY_Cont);
                            oDVAL   <= ready;
                        end
                    end else begin
                        oDVAL <= ready;
                    end
                end

                HBLANK: begin
                    if (iSTOP) stopPend <= 1'b1;
                    if (blankCnt == HB_LAST) begin
                        state   <= ACTIVE;
                        oX_Cont <= 11'd0;
                        oY_Cont <= oY_Cont + 11'd1;
                        oDATA   <= pixel(mode, 11'd0, oY_Cont + 11'd1);
                        oDVAL   <= ready;
                        oLVAL   <= 1'b1;
                    end else begin
                        blankCnt <= blankCnt + BW'(1);
                    end
                end

                VBLANK: begin
                    if (blankCnt == VB_LAST) begin
                        // A stop pulse on the exit cycle itself still counts.
                        if (stopPend || iSTOP) begin
                            state    <= IDLE;
                            stopPend <= 1'b0;
                            oX_Cont  <= 11'd0;
                            oY_Cont  <= 11'd0;
                            oBUSY    <= 1'b0;
                        end else begin
                            state   <= ACTIVE;
                            mode    <= iMODE;
                            oX_Cont <= 11'd0;
                            oY_Cont <= 11'd0;
                            oDATA   <= pixel(iMODE, 11'd0, 11'd0);
                            oDVAL   <= ready;
                            oLVAL   <= 1'b1;
                            oFVAL   <= 1'b1;
                        end
                    end else begin
                        if (iSTOP) stopPend <= 1'b1;
                        blankCnt <= blankCnt + BW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
